// File: rtl/wb_imem_if.sv
// Wishbone pipelined bus bundle between the prefetch master
// and the instruction memory slave.
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;

  modport MASTER (
    output cyc, stb, we, addr, sel, wdata,
    input  rdata, ack, stall
  );

  modport SLAVE (
    input  cyc, stb, we, addr, sel, wdata,
    output rdata, ack, stall
  );
endinterface

// File: rtl/wb_imem.sv
// Pipelined Wishbone instruction memory: fixed-latency in-order
// responses, byte-lane writes and optional periodic stall.
module wb_imem #(
  parameter int          MEM_SIZE_POT = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          LATENCY      = 2,
  parameter int          STALL_PERIOD = 0,
  parameter string       INIT_FILE    = ""
) (
  input logic        clk_i,
  input logic        rst_i,
  wishbone_if.SLAVE  wb_if
);

  localparam int DEPTH = 1 << MEM_SIZE_POT;
  localparam int CW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

  logic [31:0] mem [DEPTH];

  logic [29:0]             idx;
  logic                    in_range;
  logic [MEM_SIZE_POT-1:0] waddr;
  logic [31:0]             rd_word;
  logic                    accept;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               stall_q, stall_d;

  assign idx      = wb_if.addr - BASE_ADDR[31:2];
  assign in_range = (idx >> MEM_SIZE_POT) == '0;
  assign waddr    = idx[MEM_SIZE_POT-1:0];
  assign rd_word  = in_range ? mem[waddr] : 32'h0;
  assign accept   = wb_if.cyc & wb_if.stb & ~stall_q;

  // Byte-lane commit at the acceptance edge; out-of-range writes drop.
  always_ff @(posedge clk_i) begin
    if (accept && wb_if.we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_if.sel[i]) mem[waddr][8*i +: 8] <= wb_if.wdata[8*i +: 8];
      end
    end
  end

  // Response shift pipe; data stages only load behind a valid entry
  // so the last stage holds rdata across bubbles. cyc low aborts.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    vld_d[0] = accept;
    if (accept) dat_d[0] = wb_if.we ? 32'h0 : rd_word;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
    if (!wb_if.cyc) vld_d = '0;
  end

  // Free-running stall phase counter; stall is its registered decode.
  always_comb begin
    cnt_d   = '0;
    stall_d = 1'b0;
    if (STALL_PERIOD != 0 && cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
    if (STALL_PERIOD != 0) stall_d = (cnt_d == CNT_LAST);
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= 32'h0;
    end else begin
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign wb_if.stall = stall_q;
  assign wb_if.ack   = vld_q[LATENCY-1] & wb_if.cyc;
  assign wb_if.rdata = dat_q[LATENCY-1];

endmodule

// File: tb/tb_wb_imem.sv
// Directed bench for wb_imem: bursts, byte writes, range, abort,
// async reset (no stall) and stall injection (period 4).
module tb_wb_imem;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  int   errs = 0;
  int   checks = 0;

  localparam logic [29:0] B = 30'h2000_0000;

  always #5 clk = ~clk;

  wishbone_if w0 ();
  wishbone_if w1 ();

  wb_imem #(.LATENCY(2), .STALL_PERIOD(0)) u_dut0 (
    .clk_i (clk),
    .rst_i (rst0),
    .wb_if (w0)
  );

  wb_imem #(.LATENCY(2), .STALL_PERIOD(4)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst1),
    .wb_if (w1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic cyc, input logic stb, input logic we,
                      input logic [29:0] a, input logic [3:0] sel,
                      input logic [31:0] d);
    w0.cyc = cyc; w0.stb = stb; w0.we = we;
    w0.addr = a; w0.sel = sel; w0.wdata = d;
  endtask

  task automatic idle0;
    drv0(1'b1, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
  endtask

  task automatic drv1(input logic cyc, input logic stb, input logic we,
                      input logic [29:0] a, input logic [31:0] d);
    w1.cyc = cyc; w1.stb = stb; w1.we = we;
    w1.addr = a; w1.sel = 4'hF; w1.wdata = d;
  endtask

  bit acc [16];
  int nacc;
  int nack;
  int pl;
  logic exp_st;
  logic exp_ack;

  initial begin
    drv0(1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    #1 rst0 = 1'b1; rst1 = 1'b1;
    #1;
    check("rst_ack",   {31'h0, w0.ack},   32'h0);
    check("rst_stall", {31'h0, w0.stall}, 32'h0);
    check("rst_rdata", w0.rdata,          32'h0);
    check("rst_stall1", {31'h0, w1.stall}, 32'h0);
    tick; tick;
    rst0 = 1'b0;

    // preload words 0, 1, 5
    drv0(1'b1, 1'b1, 1'b1, B + 30'd0, 4'hF, 32'h0000_0013); tick;
    drv0(1'b1, 1'b1, 1'b1, B + 30'd1, 4'hF, 32'h0010_0093); tick;
    drv0(1'b1, 1'b1, 1'b1, B + 30'd5, 4'hF, 32'h0); tick;
    idle0; tick; tick; tick;

    // read burst
    drv0(1'b1, 1'b1, 1'b0, B + 30'd0, 4'h0, 32'h0); tick;
    check("burst_early", {31'h0, w0.ack}, 32'h0);
    drv0(1'b1, 1'b1, 1'b0, B + 30'd1, 4'h0, 32'h0); tick;
    check("burst_ack0", {31'h0, w0.ack}, 32'h1);
    check("burst_rd0",  w0.rdata, 32'h0000_0013);
    idle0; tick;
    check("burst_ack1", {31'h0, w0.ack}, 32'h1);
    check("burst_rd1",  w0.rdata, 32'h0010_0093);
    tick;
    check("burst_done", {31'h0, w0.ack}, 32'h0);
    check("burst_hold", w0.rdata, 32'h0010_0093);

    // byte-lane write then read-after-write
    drv0(1'b1, 1'b1, 1'b1, B + 30'd5, 4'b0101, 32'hAABB_CCDD); tick;
    drv0(1'b1, 1'b1, 1'b0, B + 30'd5, 4'h0, 32'h0); tick;
    check("bw_wack", {31'h0, w0.ack}, 32'h1);
    check("bw_wdat", w0.rdata, 32'h0);
    idle0; tick;
    check("bw_rack", {31'h0, w0.ack}, 32'h1);
    check("bw_rdat", w0.rdata, 32'h00BB_00DD);
    tick;

    // out of range read and write
    drv0(1'b1, 1'b1, 1'b0, 30'h0, 4'h0, 32'h0); tick;
    idle0;
    check("oor_early", {31'h0, w0.ack}, 32'h0);
    tick;
    check("oor_rack", {31'h0, w0.ack}, 32'h1);
    check("oor_rdat", w0.rdata, 32'h0);
    drv0(1'b1, 1'b1, 1'b1, 30'h0, 4'hF, 32'hFFFF_FFFF); tick;
    idle0; tick;
    check("oor_wack", {31'h0, w0.ack}, 32'h1);
    drv0(1'b1, 1'b1, 1'b0, B + 30'd0, 4'h0, 32'h0); tick;
    idle0; tick;
    check("oor_keep_ack", {31'h0, w0.ack}, 32'h1);
    check("oor_keep_rd",  w0.rdata, 32'h0000_0013);
    tick;

    // abort: cyc low one cycle kills both pending reads
    drv0(1'b1, 1'b1, 1'b0, B + 30'd1, 4'h0, 32'h0); tick;
    drv0(1'b1, 1'b1, 1'b0, B + 30'd0, 4'h0, 32'h0); tick;
    drv0(1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0); #1;
    check("abort_gate", {31'h0, w0.ack}, 32'h0);
    tick;
    drv0(1'b1, 1'b1, 1'b0, B + 30'd5, 4'h0, 32'h0); #1;
    check("abort_kill", {31'h0, w0.ack}, 32'h0);
    tick;
    check("abort_wait", {31'h0, w0.ack}, 32'h0);
    idle0; tick;
    check("abort_new_ack", {31'h0, w0.ack}, 32'h1);
    check("abort_new_rd",  w0.rdata, 32'h00BB_00DD);
    tick;
    check("abort_after", {31'h0, w0.ack}, 32'h0);

    // async reset with a response still pending
    drv0(1'b1, 1'b1, 1'b0, B + 30'd0, 4'h0, 32'h0); tick;
    drv0(1'b1, 1'b1, 1'b0, B + 30'd1, 4'h0, 32'h0); tick;
    check("ar_ack0", {31'h0, w0.ack}, 32'h1);
    check("ar_rd0",  w0.rdata, 32'h0000_0013);
    idle0;
    #1 rst0 = 1'b1;
    #1;
    check("ar_drop",  {31'h0, w0.ack}, 32'h0);
    check("ar_rdclr", w0.rdata, 32'h0);
    tick;
    rst0 = 1'b0;
    check("ar_rel0", {31'h0, w0.ack}, 32'h0);
    tick;
    check("ar_rel1", {31'h0, w0.ack}, 32'h0);
    tick;
    check("ar_rel2", {31'h0, w0.ack}, 32'h0);
    drv0(1'b1, 1'b1, 1'b0, B + 30'd1, 4'h0, 32'h0); tick;
    idle0;
    check("ar_new_early", {31'h0, w0.ack}, 32'h0);
    tick;
    check("ar_new_ack", {31'h0, w0.ack}, 32'h1);
    check("ar_mem_keep", w0.rdata, 32'h0010_0093);

    // stall injection: preload words 0..11 with 0x100+i
    rst1 = 1'b0;
    pl = 0;
    for (int n = 0; n < 40 && pl < 12; n++) begin
      if (!w1.stall) begin
        drv1(1'b1, 1'b1, 1'b1, B + 30'(pl), 32'h100 + 32'(pl));
        pl++;
      end else begin
        drv1(1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
      end
      tick;
    end
    check("st_preload", 32'(pl), 32'd12);
    drv1(1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    tick; tick; tick;
    rst1 = 1'b1;
    tick;
    rst1 = 1'b0;
    nacc = 0;
    nack = 0;
    for (int c = 0; c < 16; c++) begin
      exp_st = (c % 4) == 3;
      if (c >= 12) exp_st = w1.stall;
      if (c < 12) check($sformatf("st_stall%0d", c), {31'h0, w1.stall},
                        {31'h0, exp_st});
      exp_ack = (c >= 2) ? acc[c-2] : 1'b0;
      check($sformatf("st_ack%0d", c), {31'h0, w1.ack}, {31'h0, exp_ack});
      if (w1.ack) begin
        check($sformatf("st_rd%0d", nack), w1.rdata, 32'h100 + 32'(nack));
        nack++;
      end
      if (c < 12) begin
        drv1(1'b1, 1'b1, 1'b0, B + 30'(nacc), 32'h0);
        acc[c] = ((c % 4) != 3);
        if ((c % 4) != 3) nacc++;
      end else begin
        drv1(1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
        acc[c] = 1'b0;
      end
      tick;
    end
    check("st_nack", 32'(nack), 32'd9);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
